// File: rtl/river_pkg.sv
// Shared widths and enums for the river sprite ROM arbiter.
package river_pkg;

    localparam int unsigned ROM_AW = 11;
    localparam int unsigned ROM_DW = 4;
    localparam int unsigned WAIT_W = 16;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_AUX  = 1'b1
    } owner_e;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_DATA = 1'b1
    } arb_state_e;

endpackage

// File: rtl/river_tag_pipe.sv
// Ownership tag delay line, matched to the ROM read latency so returning
// data can be steered to whichever requester issued the address.
module river_tag_pipe
    import river_pkg::*;
#(
    parameter int unsigned DEPTH = 1
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tag,
    output logic o_tag
);

    owner_e r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= OWN_DISP;
            end
        end else begin
            r_pipe[0] <= owner_e'(i_tag);
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = 1'(r_pipe[DEPTH-1]);

endmodule

// File: rtl/river_rom_arbiter.sv
// Shares the river sprite ROM between the display path (owner during active
// video) and an aux reader served in blanking. Optional macro RIVER_ARB_STARVE_EN.
module river_rom_arbiter
    import river_pkg::*;
#(
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned MAX_WAIT    = 800
)(
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              blank,
    input  logic [ROM_AW-1:0] disp_addr,
    output logic [ROM_DW-1:0] disp_q,
    input  logic              aux_req,
    input  logic [ROM_AW-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [ROM_DW-1:0] aux_rdata,
    output logic              aux_starved,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [ROM_DW-1:0] rom_q
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    owner_e            w_tag_in;
    logic              w_tag_out;
    logic              w_aux_exit;
    logic [ROM_DW-1:0] r_aux_rdata;

    // State register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= A_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: stay busy until the aux tag leaves the pipe
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            A_IDLE:  if (aux_gnt)    w_state_next = A_DATA;
            A_DATA:  if (w_aux_exit) w_state_next = A_IDLE;
            default: w_state_next = A_IDLE;
        endcase
    end

    // Grant only from idle and never during active video
    always_comb begin
        aux_gnt  = 1'b0;
        w_tag_in = OWN_DISP;
        if (r_state == A_IDLE && aux_req && !blank) begin
            aux_gnt  = 1'b1;
            w_tag_in = OWN_AUX;
        end
    end

    assign rom_address = aux_gnt ? aux_addr : disp_addr;

    river_tag_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_tag_pipe (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_tag   (1'(w_tag_in)),
        .o_tag   (w_tag_out)
    );

    assign w_aux_exit = (owner_e'(w_tag_out) == OWN_AUX);

    // Hold the last aux word so aux_rdata is stable between reads
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aux_rdata <= '0;
        end else if (w_aux_exit) begin
            r_aux_rdata <= rom_q;
        end
    end

    assign aux_rvalid = w_aux_exit;
    assign aux_rdata  = w_aux_exit ? rom_q : r_aux_rdata;
    assign disp_q     = w_aux_exit ? ROM_DW'(0) : rom_q;

`ifdef RIVER_ARB_STARVE_EN
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_starved;

    // Consecutive-wait counter with sticky starvation flag
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_starved  <= 1'b0;
        end else begin
            if (!aux_req || aux_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (32'(r_wait_cnt) > MAX_WAIT) begin
                r_starved <= 1'b1;
            end
        end
    end

    assign aux_starved = r_starved;
`else
    logic w_unused_max_wait;
    assign w_unused_max_wait = (MAX_WAIT != 0);
    assign aux_starved       = 1'b0;
`endif

endmodule

// File: tb/tb_river_rom_arbiter.sv
// Randomized scoreboard bench for river_rom_arbiter with a ROM model and a
// transaction-level reference of the sharing rules.
module tb_river_rom_arbiter;
    import river_pkg::*;

    localparam int unsigned ROM_LAT = 1;
    localparam int unsigned MAXW    = 800;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        blank   = 1'b1;
    logic        aux_req = 1'b0;
    logic [10:0] disp_addr = '0;
    logic [10:0] aux_addr  = '0;
    logic [10:0] rom_address;
    logic [3:0]  disp_q, aux_rdata, rom_q;
    logic        aux_gnt, aux_rvalid, aux_starved;

    river_rom_arbiter #(
        .ROM_LATENCY (ROM_LAT),
        .MAX_WAIT    (MAXW)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .blank       (blank),
        .disp_addr   (disp_addr),
        .disp_q      (disp_q),
        .aux_req     (aux_req),
        .aux_addr    (aux_addr),
        .aux_gnt     (aux_gnt),
        .aux_rvalid  (aux_rvalid),
        .aux_rdata   (aux_rdata),
        .aux_starved (aux_starved),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM model with configurable read latency
    logic [3:0] rom_mem  [2048];
    logic [3:0] rom_pipe [ROM_LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_mem[rom_address];
        for (int i = 1; i < int'(ROM_LAT); i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [3:0] data;
    } exp_t;

    exp_t aux_q[$];
    exp_t disp_exp[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_dut_gnt = 0;
    int          n_dut_rv  = 0;
    bit          chk_en   = 1'b0;
    logic        exp_gnt  = 1'b0;
    logic [10:0] exp_addr = '0;
    logic        exp_starved = 1'b0;
    int          next_free = 0;
`ifdef RIVER_ARB_STARVE_EN
    int          wait_cnt = 0;
    bit          starve_sticky = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle and record what the sharing rules say must happen
    task automatic drive_cycle(input logic b, input logic req, input logic [10:0] aa, input logic [10:0] da);
        @(posedge vga_clk);
        #1;
        blank = b; aux_req = req; aux_addr = aa; disp_addr = da;
        exp_gnt  = req && !b && (cyc >= next_free);
        exp_addr = exp_gnt ? aa : da;
        if (exp_gnt) begin
            aux_q.push_back('{due: cyc + int'(ROM_LAT), data: rom_mem[aa]});
            next_free = cyc + int'(ROM_LAT) + 1;
        end
        disp_exp.push_back('{due: cyc + int'(ROM_LAT), data: exp_gnt ? 4'h0 : rom_mem[da]});
`ifdef RIVER_ARB_STARVE_EN
        exp_starved = starve_sticky;
        if (wait_cnt > int'(MAXW)) starve_sticky = 1'b1;
        wait_cnt = (req && !exp_gnt) ? wait_cnt + 1 : 0;
`else
        exp_starved = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 11'h0, 11'($urandom));
    endtask

    // Monitor: compares live outputs and pops the scoreboard on returns
    always @(negedge vga_clk) begin
        exp_t e;
        if (chk_en) begin
            check("aux_gnt", 32'(aux_gnt), 32'(exp_gnt));
            check("rom_address", 32'(rom_address), 32'(exp_addr));
            check("aux_starved", 32'(aux_starved), 32'(exp_starved));
            if (aux_gnt) n_dut_gnt++;
            if (disp_exp.size() > 0 && disp_exp[0].due == cyc) begin
                e = disp_exp.pop_front();
                check("disp_q", 32'(disp_q), 32'(e.data));
            end
            if (aux_rvalid) begin
                n_dut_rv++;
                if (aux_q.size() == 0) begin
                    check("aux_rvalid_spurious", 32'(aux_rvalid), 32'(0));
                end else begin
                    e = aux_q.pop_front();
                    check("aux_rvalid_cycle", 32'(cyc), 32'(e.due));
                    check("aux_rdata", 32'(aux_rdata), 32'(e.data));
                end
            end else if (aux_q.size() > 0 && aux_q[0].due <= cyc) begin
                e = aux_q.pop_front();
                check("aux_rvalid_missing", 32'(aux_rvalid), 32'(1));
            end
        end
    end

    initial begin
        int          g0, r0;
        logic        rb, rreq, prev_gnt;
        logic [10:0] raddr;

        for (int i = 0; i < 2048; i++) rom_mem[i] = 4'($urandom);
        rom_mem[11'h123] = 4'hA;

        repeat (2) @(posedge vga_clk);
        #1;
        check("rst_aux_gnt", 32'(aux_gnt), 32'(0));
        check("rst_aux_rvalid", 32'(aux_rvalid), 32'(0));
        check("rst_aux_rdata", 32'(aux_rdata), 32'(0));
        check("rst_aux_starved", 32'(aux_starved), 32'(0));
        reset_n = 1'b1;

        drive_cycle(1'b1, 1'b0, 11'h0, 11'h10);
        chk_en = 1'b1;
        idle(3);

        // Single aux read of a known location
        drive_cycle(1'b0, 1'b1, 11'h123, 11'h55);
        idle(3);

        // Long active-video stall, then grant in the first blanking cycle
        g0 = n_dut_gnt;
        for (int i = 0; i < 640; i++) drive_cycle(1'b1, 1'b1, 11'h2A7, 11'($urandom));
        drive_cycle(1'b0, 1'b1, 11'h2A7, 11'($urandom));
        drive_cycle(1'b0, 1'b0, 11'h0, 11'($urandom));
        check("grants_after_active", 32'(n_dut_gnt - g0), 32'(1));
        idle(3);

        // Back-to-back aux reads over 20 blanking cycles
        g0 = n_dut_gnt; r0 = n_dut_rv;
        raddr = 11'($urandom);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 1'b1, raddr, 11'($urandom));
            if (exp_gnt) raddr = 11'($urandom);
        end
        drive_cycle(1'b0, 1'b0, 11'h0, 11'($urandom));
        check("grants_in_20", 32'(n_dut_gnt - g0), 32'(10));
        check("rvalids_in_20", 32'(n_dut_rv - r0), 32'(10));
        idle(3);

        // Grant in the last blanking cycle, active video next
        drive_cycle(1'b0, 1'b1, 11'h7F0, 11'h011);
        drive_cycle(1'b1, 1'b0, 11'h0, 11'h3C5);
        drive_cycle(1'b1, 1'b0, 11'h0, 11'h3C6);
        idle(3);

        // Randomized traffic
        rb = 1'b0; rreq = 1'b0; raddr = '0; prev_gnt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) rb = ~rb;
            if (rreq) begin
                if (prev_gnt) begin
                    if ($urandom_range(1) == 1) raddr = 11'($urandom);
                    else rreq = 1'b0;
                end else if ($urandom_range(19) == 0) begin
                    rreq = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                rreq  = 1'b1;
                raddr = 11'($urandom);
            end
            drive_cycle(rb, rreq, raddr, 11'($urandom));
            prev_gnt = exp_gnt;
        end
        idle(4);

        // Starvation window, then the grant; flag must persist
        for (int i = 0; i < 850; i++) drive_cycle(1'b1, 1'b1, 11'h0AB, 11'($urandom));
        drive_cycle(1'b0, 1'b1, 11'h0AB, 11'($urandom));
        idle(4);

        // Reset asserted in the middle of a granted read
        drive_cycle(1'b0, 1'b1, 11'h456, 11'($urandom));
        #1;
        check("gnt_before_reset", 32'(aux_gnt), 32'(1));
        #1;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        aux_req = 1'b0;
        #1;
        check("midrst_aux_gnt", 32'(aux_gnt), 32'(0));
        check("midrst_aux_rvalid", 32'(aux_rvalid), 32'(0));
        check("midrst_aux_rdata", 32'(aux_rdata), 32'(0));
        check("midrst_aux_starved", 32'(aux_starved), 32'(0));
        aux_q.delete();
        disp_exp.delete();
        repeat (2) @(posedge vga_clk);
        #1;
        reset_n   = 1'b1;
        next_free = 0;
`ifdef RIVER_ARB_STARVE_EN
        wait_cnt      = 0;
        starve_sticky = 1'b0;
`endif
        r0 = n_dut_rv;
        drive_cycle(1'b0, 1'b0, 11'h0, 11'($urandom));
        chk_en = 1'b1;
        idle(10);
        check("no_rvalid_after_reset", 32'(n_dut_rv - r0), 32'(0));
        check("aux_queue_drained", 32'(aux_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
